// File: rtl/cms_param_if.sv
// rtl/cms_param_if.sv - request/sample/result bundle for the mean-square engine
`timescale 1ns/1ps
interface cms_param_if #(
   parameter int DW = 16
);
   localparam int RW = 2*DW+3;

   logic          start;
   logic [3:0]    log2n;
   logic [2*DW-1:0] y;
   logic [2*DW-1:0] y_hat;
   logic          next_number;
   logic          busy;
   logic          done;
   logic [RW-1:0] result;

   modport master (
      output start, log2n, y, y_hat,
      input  next_number, busy, done, result
   );

   modport slave (
      input  start, log2n, y, y_hat,
      output next_number, busy, done, result
   );
endinterface

// File: rtl/cms_param.sv
// rtl/cms_param.sv - mean of |y - y_hat|^2 over 2^log2n samples; CMS_ROUND_EN selects round-half-up on the final divide
`timescale 1ns/1ps
module cms_param #(
   parameter int DW        = 16,
   parameter int MAX_LOG2N = 7
) (
   input  logic      clk,
   input  logic      reset,
   cms_param_if.slave bus
);
   localparam int RW = 2*DW+3;
   localparam int AW = RW + MAX_LOG2N;
   localparam int CW = MAX_LOG2N + 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t                 state, state_nx;
   logic [3:0]             ne, ne_req;
   logic [CW-1:0]          cnt, n_last;
   logic [1:0]             dcnt;
   logic                   v1, v2;
   logic signed [DW:0]     dr, di;
   logic signed [2*DW+1:0] pr, pi;
   logic [RW-1:0]          m;
   logic [AW-1:0]          acc;
   logic [RW-1:0]          res, res_nx;
   logic                   go;

   assign ne_req = (bus.log2n > 4'(MAX_LOG2N)) ? 4'(MAX_LOG2N) : bus.log2n;
   assign n_last = (CW'(1) << ne) - CW'(1);
   assign go     = (state == IDLE) && bus.start;
   assign pr     = dr * dr;
   assign pi     = di * di;
   assign bus.result = res;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state: DONE waits for start low so a held start cannot retrigger
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (bus.start)       state_nx = FETCH;
         FETCH: if (cnt == n_last)   state_nx = DRAIN;
         DRAIN: if (dcnt == 2'd3)    state_nx = DONE;
         DONE:  if (!bus.start)      state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
   end

   // status outputs decoded from state
   always_comb begin
      bus.next_number = 1'b0;
      bus.busy        = 1'b0;
      bus.done        = 1'b0;
      case (state)
         FETCH: begin bus.next_number = 1'b1; bus.busy = 1'b1; end
         DRAIN: bus.busy = 1'b1;
         DONE:  bus.done = 1'b1;
         default: ;
      endcase
   end

   // run control: latch clamped Ne, count fetched samples and drain cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ne   <= '0;
         cnt  <= '0;
         dcnt <= '0;
      end else begin
         if (go) begin
            ne  <= ne_req;
            cnt <= '0;
         end else if (state == FETCH) begin
            cnt <= cnt + CW'(1);
         end
         if (state == DRAIN) dcnt <= dcnt + 2'd1;
         else                dcnt <= '0;
      end
   end

   // stage 1: component differences, one bit wider so they never overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dr <= '0;
         di <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= (state == FETCH);
         if (state == FETCH) begin
            dr <= {bus.y[2*DW-1], bus.y[2*DW-1:DW]} - {bus.y_hat[2*DW-1], bus.y_hat[2*DW-1:DW]};
            di <= {bus.y[DW-1], bus.y[DW-1:0]} - {bus.y_hat[DW-1], bus.y_hat[DW-1:0]};
         end
      end
   end

   // stage 2: exact squared magnitude; both squares are non-negative
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m  <= '0;
         v2 <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) m <= {1'b0, pr} + {1'b0, pi};
      end
   end

   // stage 3: accumulator sized so 2^MAX_LOG2N worst-case samples cannot wrap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     acc <= '0;
      else if (go)    acc <= '0;
      else if (v2)    acc <= acc + AW'(m);
   end

`ifdef CMS_ROUND_EN
   logic [AW-1:0] half;

   // divide by N with round half up; Ne=0 adds nothing
   always_comb begin
      half = '0;
      if (ne != 4'd0) half = AW'(1) << (ne - 4'd1);
      res_nx = RW'((acc + half) >> ne);
   end
`else
   // divide by N with truncation
   always_comb begin
      res_nx = RW'(acc >> ne);
   end
`endif

   // result register: only written when a run completes, otherwise held
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                              res <= '0;
      else if (state == DRAIN && dcnt == 2'd3) res <= res_nx;
   end
endmodule
